pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32 pipeline. It drives the stall, flush and bubble (NoP) controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and selects EX-stage operand forwarding. It also tracks multi-cycle data-memory accesses with a timeout FSM. It is purely a control block and holds no datapath state.

Parameters:
MEM_TIMEOUT, 16, max consecutive cycles a data-memory access may wait for mem_ready before abort (>=2)
CNT_W, 5, width of wait counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous reset, active-low
id_rs1  in  5  ID source reg 1
id_rs2  in  5  ID source reg 2
id_rs1_used  in  1  ID instr reads rs1
id_rs2_used  in  1  ID instr reads rs2
ex_rs1  in  5  EX source reg 1 (forwarding)
ex_rs2  in  5  EX source reg 2
ex_rd  in  5  EX destination
ex_RegWEn  in  1  EX writes rd
ex_MemEn  in  1  EX is memory op
ex_MemRW  in  1  EX mem dir, 0=load 1=store
ex_branch_taken  in  1  EX resolved taken branch/jump
mem_rd  in  5  MEM destination
mem_RegWEn  in  1  MEM writes rd
mem_MemEn  in  1  MEM stage accessing data memory
mem_ready  in  1  data memory completes access this cycle
wb_rd  in  5  WB destination
wb_RegWEn  in  1  WB writes rd
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  load NoP into IF/ID
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  load NoP into ID/EX (ex_NoP_en=1)
ex_mem_stall  out  1  hold EX/MEM
mem_wb_bubble  out  1  load NoP into MEM/WB
fwd_a_sel  out  2  EX operand A: 00 regfile, 01 MEM ALU_out, 10 WB data
fwd_b_sel  out  2  EX operand B, same encoding
mem_err  out  1  sticky: a memory access timed out
ctrl_state  out  2  FSM state, for debug

Behaviour:
- FSM states: RUN=00, WAIT=01, ABORT=10. Reset state is RUN. Wait counter resets to 0; mem_err resets to 0.
- While rst=0: all stall outputs 0, if_id_flush=1, id_ex_flush=1, mem_wb_bubble=1, fwd sels 00.
- All control outputs are combinational from state and inputs. State, counter and mem_err are registered, updated on posedge clk.
- Mem stall condition: memstall = mem_MemEn & ~mem_ready, evaluated in RUN or WAIT.
  - When asserted: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall =1; mem_wb_bubble=1; no flushes.
  - Mem stall has highest priority.
- RUN->WAIT on memstall, counter<=1.
- WAIT: counter++ each cycle. mem_ready=1 -> RUN, counter<=0, no stall that cycle.
  - counter==MEM_TIMEOUT-1 with mem_ready=0 -> ABORT.
- ABORT (1 cycle): no stalls, mem_wb_bubble=1 (access dropped), mem_err<=1. Next state RUN.
- Branch (RUN, no memstall): ex_branch_taken=1 -> if_id_flush=1, id_ex_flush=1 (2 bubbles). No stalls.
  - Branch beats load-use.
  - Branch held during a memstall is applied on the release cycle, since ex_branch_taken stays stable.
- Load-use (RUN, no memstall, no branch):
  - Detect: ex_MemEn & ~ex_MemRW & ex_RegWEn & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - Response: pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly one cycle.
- Forwarding per operand:
  - 01 if mem_RegWEn & mem_rd!=0 & mem_rd==ex_rsX.
  - Else 10 if wb_RegWEn & wb_rd!=0 & wb_rd==ex_rsX.
  - Else 00. MEM wins over WB.
  - x0 is never forwarded.
- Reset mid-WAIT: state returns to RUN immediately (async). Counter and mem_err are cleared.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0], both reset to 0. stall_cnt increments each cycle pc_stall=1. flush_cnt increments each cycle if_id_flush=1 while rst=1. Both wrap at 2^32.
- Undefined: ports and logic are absent.

Test Plan:
- Reset: rst=0 -> flushes=1, mem_wb_bubble=1, stalls=0, ctrl_state=00, mem_err=0. Release -> all 0.
- Load-use: ex load rd=5, id_rs1=5 used -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; then 0. Same case with ex_rd=0 -> no stall.
- Branch: ex_branch_taken=1 together with a load-use match -> if_id_flush=1, id_ex_flush=1, pc_stall=0.
- Mem wait: mem_MemEn=1, mem_ready low for 3 cycles -> 3 stall cycles, ctrl_state 01. Ready -> RUN, stalls drop the same cycle.
- Timeout (MEM_TIMEOUT=16): mem_ready never asserted -> 16 stall cycles, then ABORT with mem_wb_bubble=1 and mem_err=1 sticky, then RUN.
- Forwarding: mem_rd=wb_rd=7, both RegWEn, ex_rs1=7 -> fwd_a_sel=01. With mem_RegWEn=0 -> 10. With ex_rs1=0 -> 00.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard, flush/stall and forwarding controller for the 5-stage RV32 pipeline
// Ports: clk; rst (async, active-low); ID/EX/MEM/WB register ids and enables in;
//        stall/flush/bubble controls for PC, IF/ID, ID/EX, EX/MEM, MEM/WB out;
//        fwd_a_sel/fwd_b_sel (00 regfile, 01 MEM ALU_out, 10 WB data); mem_err sticky; ctrl_state debug.
// Optional: define PIPE_CTRL_PERF_EN to add stall_cnt/flush_cnt performance counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_RegWEn,
    input  logic       ex_MemEn,
    input  logic       ex_MemRW,
    input  logic       ex_branch_taken,
    input  logic [4:0] mem_rd,
    input  logic       mem_RegWEn,
    input  logic       mem_MemEn,
    input  logic       mem_ready,
    input  logic [4:0] wb_rd,
    input  logic       wb_RegWEn,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_stall,
    output logic       id_ex_flush,
    output logic       ex_mem_stall,
    output logic       mem_wb_bubble,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic       mem_err,
    output logic [1:0] ctrl_state
);
    typedef enum logic [1:0] {S_RUN = 2'b00, S_WAIT = 2'b01, S_ABORT = 2'b10} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             memstall, active, branch, load_use;
    function automatic logic [1:0] fwd(input logic [4:0] rs);
        return (mem_RegWEn && mem_rd != 5'd0 && mem_rd == rs) ? 2'b01 :
               (wb_RegWEn && wb_rd != 5'd0 && wb_rd == rs)    ? 2'b10 : 2'b00;
    endfunction
    // ABORT drops the pending access, so a still-unready memory does not stall that cycle.
    assign memstall = rst & mem_MemEn & ~mem_ready & (state != S_ABORT);
    // Branch and load-use also act on the WAIT release cycle, since EX holds stable through the stall.
    assign active   = rst & ~memstall & (state != S_ABORT);
    assign branch   = active & ex_branch_taken;
    assign load_use = active & ~branch & ex_MemEn & ~ex_MemRW & ex_RegWEn & (ex_rd != 5'd0) &
                      ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
    assign pc_stall      = memstall | load_use;
    assign if_id_stall   = memstall | load_use;
    assign id_ex_stall   = memstall;
    assign ex_mem_stall  = memstall;
    assign if_id_flush   = ~rst | branch;
    assign id_ex_flush   = ~rst | branch | load_use;
    assign mem_wb_bubble = ~rst | memstall | (state == S_ABORT);
    assign fwd_a_sel     = rst ? fwd(ex_rs1) : 2'b00;
    assign fwd_b_sel     = rst ? fwd(ex_rs2) : 2'b00;
    assign ctrl_state    = state;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_RUN;
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            unique case (state)
                S_RUN: if (memstall) begin
                    state <= S_WAIT;
                    cnt   <= CNT_W'(1);
                end
                S_WAIT: if (!memstall) begin
                    state <= S_RUN;
                    cnt   <= '0;
                end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state   <= S_ABORT;
                    mem_err <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                default: begin
                    state <= S_RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end
`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 32'(pc_stall);
            flush_cnt <= flush_cnt + 32'(if_id_flush);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against a cycle-level reference model
module tb_pipe_hazard_ctrl;
    localparam int TO = 16;
    logic       clk = 1'b0, rst = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_rs1_used, id_rs2_used, ex_RegWEn, ex_MemEn, ex_MemRW, ex_branch_taken;
    logic       mem_RegWEn, mem_MemEn, mem_ready, wb_RegWEn;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble;
    logic [1:0] fwd_a_sel, fwd_b_sel, ctrl_state;
    logic       mem_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt, m_stall_cnt = 0, m_flush_cnt = 0;
`endif
    int vectors = 0, miscompares = 0;
    int waited = 0;
    bit abort_now = 0, err = 0;
    bit e_pc = 0, e_iff = 1;
    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_RegWEn(ex_RegWEn),
        .ex_MemEn(ex_MemEn), .ex_MemRW(ex_MemRW), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_RegWEn(mem_RegWEn), .mem_MemEn(mem_MemEn), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_RegWEn(wb_RegWEn),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .mem_wb_bubble(mem_wb_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .mem_err(mem_err), .ctrl_state(ctrl_state)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (!rst) return 2'b00;
        if (mem_RegWEn && mem_rd != 0 && mem_rd == rs) return 2'b01;
        if (wb_RegWEn && wb_rd != 0 && wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction
    task automatic clear_inputs();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_rs1_used, id_rs2_used, ex_RegWEn, ex_MemEn, ex_MemRW, ex_branch_taken} = '0;
        {mem_RegWEn, mem_MemEn, mem_ready, wb_RegWEn} = '0;
    endtask
    task automatic rand_inputs();
        id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
        ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
        {id_rs1_used, id_rs2_used, ex_RegWEn, ex_MemRW, mem_RegWEn, wb_RegWEn} = 6'($urandom);
        ex_MemEn        = ($urandom_range(0, 1) == 0);
        ex_branch_taken = ($urandom_range(0, 4) == 0);
        mem_MemEn       = ($urandom_range(0, 2) == 0);
        mem_ready       = ($urandom_range(0, 3) == 0);
    endtask
    task automatic check_cycle();
        bit ms, act, br, lu;
        ms  = rst && !abort_now && mem_MemEn && !mem_ready;
        act = rst && !abort_now && !ms;
        br  = act && ex_branch_taken;
        lu  = act && !br && ex_MemEn && !ex_MemRW && ex_RegWEn && ex_rd != 0 &&
              ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        e_pc  = ms || lu;
        e_iff = !rst || br;
        chk("ctrl", {25'd0, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_bubble},
            {25'd0, e_pc, e_pc, ms, ms, e_iff, !rst || br || lu, !rst || ms || abort_now});
        chk("fwd_a", 32'(fwd_a_sel), 32'(m_fwd(ex_rs1)));
        chk("fwd_b", 32'(fwd_b_sel), 32'(m_fwd(ex_rs2)));
        chk("state", 32'(ctrl_state), abort_now ? 32'd2 : (waited > 0 ? 32'd1 : 32'd0));
        chk("mem_err", 32'(mem_err), 32'(err));
`ifdef PIPE_CTRL_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall_cnt);
        chk("flush_cnt", flush_cnt, m_flush_cnt);
`endif
    endtask
    task automatic model_reset();
        waited = 0; abort_now = 0; err = 0;
`ifdef PIPE_CTRL_PERF_EN
        m_stall_cnt = 0; m_flush_cnt = 0;
`endif
    endtask
    // Called at a negedge with inputs already set; checks, then advances the model over the next posedge.
    task automatic apply();
        #1 check_cycle();
        @(posedge clk);
        if (rst) begin
`ifdef PIPE_CTRL_PERF_EN
            m_stall_cnt += 32'(e_pc);
            m_flush_cnt += 32'(e_iff);
`endif
            if (abort_now) begin
                abort_now = 0; waited = 0;
            end else if (mem_MemEn && !mem_ready) begin
                waited++;
                if (waited == TO) begin abort_now = 1; err = 1; end
            end else waited = 0;
        end
        @(negedge clk);
    endtask
    initial begin
        clear_inputs();
        model_reset();
        @(negedge clk);
        rand_inputs(); apply();
        rand_inputs(); apply();
        rst = 1'b1;
        clear_inputs(); apply();
        ex_MemEn = 1; ex_RegWEn = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1; apply();
        clear_inputs(); apply();
        ex_MemEn = 1; ex_RegWEn = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1; apply();
        ex_rd = 5; id_rs1 = 5; ex_branch_taken = 1; apply();
        clear_inputs();
        mem_MemEn = 1;
        repeat (3) apply();
        mem_ready = 1; apply();
        clear_inputs(); apply();
        mem_MemEn = 1;
        repeat (TO + 2) apply();
        clear_inputs(); apply();
        mem_rd = 7; wb_rd = 7; mem_RegWEn = 1; wb_RegWEn = 1; ex_rs1 = 7; ex_rs2 = 7; apply();
        mem_RegWEn = 0; apply();
        ex_rs1 = 0; apply();
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 499) begin
                clear_inputs(); mem_MemEn = 1;
                repeat (5) apply();
                #2 rst = 1'b0;
                model_reset();
                #1 check_cycle();
                @(negedge clk);
                rst = 1'b1;
            end else if (i % 700 == 350) begin
                clear_inputs(); mem_MemEn = 1;
                repeat (TO + 1) apply();
            end else begin
                rand_inputs(); apply();
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
